// File: rtl/pong_physics_engine.sv
// Pong frame-update engine: moves paddles and ball once per vertical-blank rising edge,
// resolves wall bounces, paddle hits and misses, then commits all outputs together.
module pong_physics_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int POS_W       = 10,
  parameter int SPEED_W     = 8,
  parameter int SPEED_SHIFT = 5,
  parameter int PADDLE_H    = 40,
  parameter int PADDLE_W    = 8,
  parameter int BALL_SIZE   = 8,
  parameter int PAD0_X      = 16,
  parameter int BALL_SPEED  = 2,
  parameter int MAX_SPEED   = 7,
  parameter int P1_MODE     = 0,
  parameter int AI_STEP     = 3
) (
  input  logic               clk_25MHz,
  input  logic               reset_n,
  input  logic               new_data0,
  input  logic [SPEED_W-1:0] paddle0_speed,
  input  logic               paddle0_dir,
  input  logic               new_data1,
  input  logic [SPEED_W-1:0] paddle1_speed,
  input  logic               paddle1_dir,
  input  logic               vert_blank,
  output logic [POS_W-1:0]   paddle0_pos,
  output logic [POS_W-1:0]   paddle1_pos,
  output logic [POS_W-1:0]   ball_pos_x,
  output logic [POS_W-1:0]   ball_pos_y,
  output logic [3:0]         score0,
  output logic [3:0]         score1,
  output logic               frame_done
);

  localparam int SW = POS_W + 2;
  typedef logic signed [SW-1:0] spos_t;

  localparam spos_t ZERO       = {SW{1'b0}};
  localparam spos_t PAD_MAX    = spos_t'(SCREEN_H - PADDLE_H);
  localparam spos_t PAD_INIT   = spos_t'((SCREEN_H - PADDLE_H) / 2);
  localparam spos_t BALL_X0    = spos_t'((SCREEN_W - BALL_SIZE) / 2);
  localparam spos_t BALL_Y0    = spos_t'((SCREEN_H - BALL_SIZE) / 2);
  localparam spos_t BALL_X_MAX = spos_t'(SCREEN_W - BALL_SIZE);
  localparam spos_t BALL_Y_MAX = spos_t'(SCREEN_H - BALL_SIZE);
  localparam spos_t PAD0_LEFT  = spos_t'(PAD0_X);
  localparam spos_t PAD0_RIGHT = spos_t'(PAD0_X + PADDLE_W);
  localparam spos_t PAD1_LEFT  = spos_t'(SCREEN_W - PAD0_X - PADDLE_W);
  localparam spos_t PAD1_RIGHT = spos_t'(SCREEN_W - PAD0_X);
  localparam spos_t BALL_SZ    = spos_t'(BALL_SIZE);
  localparam spos_t PAD_HT     = spos_t'(PADDLE_H);
  localparam spos_t SERVE_V    = spos_t'(BALL_SPEED);
  localparam spos_t VMAX       = spos_t'(MAX_SPEED);
  localparam spos_t AI_MAX     = spos_t'(AI_STEP);
  localparam spos_t CENTRE_OFS = spos_t'(PADDLE_H / 2 - BALL_SIZE / 2);

  typedef enum logic [2:0] {IDLE, MOVE_PAD, MOVE_BALL, COLLIDE, COMMIT} state_t;

  function automatic spos_t clamp_pad(input spos_t v);
    spos_t r;
    if (v < ZERO) r = ZERO;
    else if (v > PAD_MAX) r = PAD_MAX;
    else r = v;
    return r;
  endfunction

  function automatic spos_t abs_s(input spos_t v);
    return (v < ZERO) ? -v : v;
  endfunction

  function automatic spos_t bump_speed(input spos_t v);
    spos_t inc;
    inc = abs_s(v) + spos_t'(1);
    return (inc > VMAX) ? VMAX : inc;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  state_t state_r, state_n;
  logic vb_r, armed_r, rise_s;
  logic [SPEED_W-1:0] vel0_r, vel1_r;
  logic dir0_r, dir1_r;
  spos_t pad0_r, pad1_r, bx_r, by_r, vx_r, vy_r;
  spos_t pad0_n, pad1_n, bx_n, by_n, vx_n, vy_n;
  logic [3:0] s0_r, s1_r, s0_n, s1_n;
  spos_t step0_s, step1_s, ai_diff_s, ai_step_s, bx_mv_s, by_mv_s;
  logic y_ov0_s, y_ov1_s, hit0_s, hit1_s;

  // armed_r blocks a level that was already high when reset released
  assign rise_s    = vert_blank & ~vb_r & armed_r;
  assign step0_s   = spos_t'(vel0_r);
  assign step1_s   = spos_t'(vel1_r);
  assign ai_diff_s = by_r - pad1_r - CENTRE_OFS;
  assign ai_step_s = (abs_s(ai_diff_s) > AI_MAX) ? AI_MAX : abs_s(ai_diff_s);
  assign bx_mv_s   = bx_r + vx_r;
  assign by_mv_s   = by_r + vy_r;
  assign y_ov0_s   = (by_r + BALL_SZ > pad0_r) && (by_r < pad0_r + PAD_HT);
  assign y_ov1_s   = (by_r + BALL_SZ > pad1_r) && (by_r < pad1_r + PAD_HT);
  assign hit0_s    = (vx_r < ZERO) && (bx_r <= PAD0_RIGHT) && (bx_r + BALL_SZ > PAD0_LEFT) && y_ov0_s;
  assign hit1_s    = (vx_r > ZERO) && (bx_r + BALL_SZ >= PAD1_LEFT) && (bx_r < PAD1_RIGHT) && y_ov1_s;

  // Next-state sequencing: one cycle per update phase
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:      state_n = rise_s ? MOVE_PAD : IDLE;
      MOVE_PAD:  state_n = MOVE_BALL;
      MOVE_BALL: state_n = COLLIDE;
      COLLIDE:   state_n = COMMIT;
      COMMIT:    state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Per-phase datapath for the internal game state
  always_comb begin
    pad0_n = pad0_r;
    pad1_n = pad1_r;
    bx_n   = bx_r;
    by_n   = by_r;
    vx_n   = vx_r;
    vy_n   = vy_r;
    s0_n   = s0_r;
    s1_n   = s1_r;
    case (state_r)
      MOVE_PAD: begin
        pad0_n = clamp_pad(dir0_r ? pad0_r - step0_s : pad0_r + step0_s);
        if (P1_MODE != 0) pad1_n = clamp_pad(dir1_r ? pad1_r - step1_s : pad1_r + step1_s);
        else pad1_n = clamp_pad((ai_diff_s < ZERO) ? pad1_r - ai_step_s : pad1_r + ai_step_s);
      end
      MOVE_BALL: begin
        bx_n = bx_mv_s;
        if (by_mv_s < ZERO) begin
          by_n = ZERO;
          vy_n = -vy_r;
        end else if (by_mv_s > BALL_Y_MAX) begin
          by_n = BALL_Y_MAX;
          vy_n = -vy_r;
        end else begin
          by_n = by_mv_s;
        end
      end
      COLLIDE: begin
        // hits are checked first so a hit on the edge column never scores
        if (hit0_s) begin
          bx_n = PAD0_RIGHT;
          vx_n = bump_speed(vx_r);
        end else if (hit1_s) begin
          bx_n = PAD1_LEFT - BALL_SZ;
          vx_n = -bump_speed(vx_r);
        end else if (bx_r <= ZERO) begin
          s1_n = sat_inc(s1_r);
          bx_n = BALL_X0;
          by_n = BALL_Y0;
          vx_n = -SERVE_V;
          vy_n = (vy_r < ZERO) ? -SERVE_V : SERVE_V;
        end else if (bx_r >= BALL_X_MAX) begin
          s0_n = sat_inc(s0_r);
          bx_n = BALL_X0;
          by_n = BALL_Y0;
          vx_n = SERVE_V;
          vy_n = (vy_r < ZERO) ? -SERVE_V : SERVE_V;
        end else begin
          vx_n = vx_r;
        end
      end
      default: begin
        vx_n = vx_r;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else state_r <= state_n;
  end

  // Edge detect, command latches and internal game state
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      vb_r    <= 1'b0;
      armed_r <= 1'b0;
      vel0_r  <= {SPEED_W{1'b0}};
      vel1_r  <= {SPEED_W{1'b0}};
      dir0_r  <= 1'b0;
      dir1_r  <= 1'b0;
      pad0_r  <= PAD_INIT;
      pad1_r  <= PAD_INIT;
      bx_r    <= BALL_X0;
      by_r    <= BALL_Y0;
      vx_r    <= SERVE_V;
      vy_r    <= SERVE_V;
      s0_r    <= 4'd0;
      s1_r    <= 4'd0;
    end else begin
      vb_r    <= vert_blank;
      armed_r <= armed_r | ~vert_blank;
      if (new_data0) begin
        vel0_r <= paddle0_speed >> SPEED_SHIFT;
        dir0_r <= paddle0_dir;
      end
      if (new_data1) begin
        vel1_r <= paddle1_speed >> SPEED_SHIFT;
        dir1_r <= paddle1_dir;
      end
      pad0_r <= pad0_n;
      pad1_r <= pad1_n;
      bx_r   <= bx_n;
      by_r   <= by_n;
      vx_r   <= vx_n;
      vy_r   <= vy_n;
      s0_r   <= s0_n;
      s1_r   <= s1_n;
    end
  end

  // Visible outputs change together, only in COMMIT
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      paddle0_pos <= PAD_INIT[POS_W-1:0];
      paddle1_pos <= PAD_INIT[POS_W-1:0];
      ball_pos_x  <= BALL_X0[POS_W-1:0];
      ball_pos_y  <= BALL_Y0[POS_W-1:0];
      score0      <= 4'd0;
      score1      <= 4'd0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= (state_r == COMMIT);
      if (state_r == COMMIT) begin
        paddle0_pos <= pad0_r[POS_W-1:0];
        paddle1_pos <= pad1_r[POS_W-1:0];
        ball_pos_x  <= bx_r[POS_W-1:0];
        ball_pos_y  <= by_r[POS_W-1:0];
        score0      <= s0_r;
        score1      <= s1_r;
      end
    end
  end

endmodule

// File: tb/tb_pong_physics_engine.sv
// Randomised scoreboard bench for pong_physics_engine against a frame-level game model.
module tb_pong_physics_engine;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int PH = 40;
  localparam int BS = 8;
  localparam int P0L = 16;
  localparam int P0R = 24;
  localparam int P1L = 616;
  localparam int P1R = 624;

  logic       clk_25MHz = 1'b0;
  logic       reset_n;
  logic       new_data0, paddle0_dir, new_data1, paddle1_dir, vert_blank;
  logic [7:0] paddle0_speed, paddle1_speed;
  logic [9:0] paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y;
  logic [3:0] score0, score1;
  logic       frame_done;

  pong_physics_engine dut (
    .clk_25MHz(clk_25MHz), .reset_n(reset_n),
    .new_data0(new_data0), .paddle0_speed(paddle0_speed), .paddle0_dir(paddle0_dir),
    .new_data1(new_data1), .paddle1_speed(paddle1_speed), .paddle1_dir(paddle1_dir),
    .vert_blank(vert_blank),
    .paddle0_pos(paddle0_pos), .paddle1_pos(paddle1_pos),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .score0(score0), .score1(score1), .frame_done(frame_done)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct {
    int done_e;
    int p0; int p1; int bx; int by; int s0; int s1;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_c;
  longint pre_pack;
  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  int m_p0, m_p1, m_bx, m_by, m_vx, m_vy, m_s0, m_s1;
  int m_vel0, m_dir0, m_prev_vb, m_armed, m_start, m_pending;

  always @(posedge clk_25MHz) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  function automatic longint pack(input int p0, input int p1, input int bx, input int by,
                                  input int s0, input int s1);
    return longint'({p0[9:0], p1[9:0], bx[9:0], by[9:0], s0[3:0], s1[3:0]});
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_p0 = 220; m_p1 = 220; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
    m_s0 = 0; m_s1 = 0; m_vel0 = 0; m_dir0 = 0;
    m_prev_vb = 0; m_armed = 0; m_start = -100; m_pending = 0;
    last_c = '{0, 220, 220, 316, 236, 0, 0};
  endtask

  // One whole game frame, straight from the rules of play.
  task automatic model_frame(output exp_t x);
    int diff, st, spd;
    m_p0 = clampi(m_p0 + (m_dir0 != 0 ? -m_vel0 : m_vel0), 0, SCR_H - PH);
    diff = (m_by + BS / 2) - (m_p1 + PH / 2);
    st = (iabs(diff) < 3) ? iabs(diff) : 3;
    m_p1 = clampi(m_p1 + (diff < 0 ? -st : st), 0, SCR_H - PH);
    m_bx = m_bx + m_vx;
    m_by = m_by + m_vy;
    if (m_by < 0) begin m_by = 0; m_vy = -m_vy; end
    else if (m_by > SCR_H - BS) begin m_by = SCR_H - BS; m_vy = -m_vy; end
    spd = (iabs(m_vx) + 1 > 7) ? 7 : iabs(m_vx) + 1;
    if (m_vx < 0 && m_bx <= P0R && m_bx + BS > P0L && m_by + BS > m_p0 && m_by < m_p0 + PH) begin
      m_bx = P0R; m_vx = spd;
    end else if (m_vx > 0 && m_bx + BS >= P1L && m_bx < P1R && m_by + BS > m_p1 && m_by < m_p1 + PH) begin
      m_bx = P1L - BS; m_vx = -spd;
    end else if (m_bx <= 0 || m_bx >= SCR_W - BS) begin
      if (m_bx <= 0) begin
        m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_vx = -2;
      end else begin
        m_s0 = (m_s0 < 15) ? m_s0 + 1 : 15; m_vx = 2;
      end
      m_bx = 316; m_by = 236; m_vy = (m_vy < 0) ? -2 : 2;
    end
    x = '{m_start + 4, m_p0, m_p1, m_bx, m_by, m_s0, m_s1};
  endtask

  // What the DUT does at clock edge e with these sampled inputs.
  task automatic model_edge(input int e, input logic nd, input int spd, input logic dir, input logic vb);
    exp_t x;
    if (m_pending != 0 && e == m_start + 1) begin
      model_frame(x);
      sb_q.push_back(x);
      m_pending = 0;
    end
    if (nd) begin m_vel0 = spd / 32; m_dir0 = dir; end
    if (vb && m_prev_vb == 0 && m_armed != 0 && e >= m_start + 5) begin
      m_start = e; m_pending = 1;
    end
    if (!vb) m_armed = 1;
    m_prev_vb = vb;
  endtask

  // Called at a negedge: apply inputs for the next posedge, then wait one cycle.
  task automatic drive(input logic nd, input int spd, input logic dir, input logic vb);
    new_data0 = nd; paddle0_speed = spd[7:0]; paddle0_dir = dir; vert_blank = vb;
    new_data1 = 1'($urandom_range(0, 1)); paddle1_speed = 8'($urandom_range(0, 255));
    paddle1_dir = 1'($urandom_range(0, 1));
    model_edge(edge_cnt + 1, nd, spd, dir, vb);
    @(negedge clk_25MHz);
  endtask

  task automatic plain_frame();
    drive(1'b0, 0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic random_slot();
    int lo, hi;
    lo = $urandom_range(1, 4);
    hi = $urandom_range(1, 6);
    for (int i = 0; i < lo + hi; i++)
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 255), 1'($urandom_range(0, 1)), (i >= lo));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pad0"}, paddle0_pos, 220);
    chk({tag, "_pad1"}, paddle1_pos, 220);
    chk({tag, "_ball"}, {ball_pos_x, ball_pos_y}, {10'd316, 10'd236});
    chk({tag, "_scores"}, {score0, score1}, 8'd0);
    chk({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Scoreboard monitor: every frame_done must match the oldest expected frame.
  always @(negedge clk_25MHz) begin : monitor
    exp_t x;
    if (reset_n) begin
      if (frame_done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_frame_done", frame_done, 0);
        end else begin
          x = sb_q.pop_front();
          chk("latency", edge_cnt, x.done_e);
          chk("hold_before_commit", pre_pack, pack(last_c.p0, last_c.p1, last_c.bx, last_c.by, last_c.s0, last_c.s1));
          chk("paddle0_pos", paddle0_pos, x.p0);
          chk("paddle1_pos", paddle1_pos, x.p1);
          chk("ball_pos_x", ball_pos_x, x.bx);
          chk("ball_pos_y", ball_pos_y, x.by);
          chk("score0", score0, x.s0);
          chk("score1", score1, x.s1);
          last_c = x;
        end
      end else if (sb_q.size() > 0 && sb_q[0].done_e < edge_cnt) begin
        chk("frame_done", frame_done, 1);
        void'(sb_q.pop_front());
      end
    end
    pre_pack = pack(paddle0_pos, paddle1_pos, ball_pos_x, ball_pos_y, score0, score1);
  end

  initial begin
    reset_n = 1'b0;
    new_data0 = 1'b0; paddle0_speed = 8'd0; paddle0_dir = 1'b0;
    new_data1 = 1'b0; paddle1_speed = 8'd0; paddle1_dir = 1'b0;
    vert_blank = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_25MHz);
    check_reset_values("reset");
    reset_n = 1'b1;

    // speed 200 >> 5 = 6 pixels down
    drive(1'b1, 200, 1'b0, 1'b0);
    repeat (7) drive(1'b0, 0, 1'b0, 1'b1);
    chk("first_frame_pad0", paddle0_pos, 226);

    // full speed down must stop at the bottom stop
    drive(1'b1, 255, 1'b0, 1'b0);
    repeat (40) plain_frame();
    chk("pad0_bottom_clamp", paddle0_pos, 440);
    plain_frame();
    chk("pad0_stays_clamped", paddle0_pos, 440);

    repeat (3500) random_slot();

    // reset during MOVE_BALL, with vert_blank held high across release
    repeat (6) drive(1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b1);
    reset_n = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    check_reset_values("midframe_reset");
    repeat (4) begin
      @(negedge clk_25MHz);
      chk("reset_frame_done_low", frame_done, 0);
    end
    reset_n = 1'b1;
    repeat (10) drive(1'b0, 0, 1'b0, 1'b1);
    chk("no_frame_from_held_vblank", {paddle0_pos, ball_pos_x}, {10'd220, 10'd316});

    repeat (600) random_slot();
    repeat (8) drive(1'b0, 0, 1'b0, 1'b0);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_physics_engine.md
PONG_PHYSICS_ENGINE -- requirements
Module: pong_physics_engine

Interface
REQ-001 SHALL have the following parameters, one per line as name, default, meaning:
- SCREEN_W, 640, active width in pixels.
- SCREEN_H, 480, active height in pixels.
- POS_W, 10, position width.
- SPEED_W, 8, paddle command speed width.
- SPEED_SHIFT, 5, command speed right-shift giving pixels per frame.
- PADDLE_H, 40, paddle height.
- PADDLE_W, 8, paddle width.
- BALL_SIZE, 8, square ball side.
- PAD0_X, 16, paddle0 left x.
- BALL_SPEED, 2, serve speed per axis.
- MAX_SPEED, 7, maximum |vx|.
- P1_MODE, 0, paddle1 control: 0 = AI tracking, 1 = external command.
- AI_STEP, 3, AI maximum pixels per frame.

REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk_25MHz, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- new_data0, in, 1, one-cycle strobe qualifying paddle0 command.
- paddle0_speed, in, SPEED_W, paddle0 speed.
- paddle0_dir, in, 1, 1 = up (y decreasing), 0 = down.
- new_data1, in, 1, paddle1 strobe; ignored when P1_MODE=0.
- paddle1_speed, in, SPEED_W, paddle1 speed; ignored when P1_MODE=0.
- paddle1_dir, in, 1, paddle1 direction; ignored when P1_MODE=0.
- vert_blank, in, 1, level; each rising edge starts one frame update.
- paddle0_pos, out, POS_W, paddle0 top y.
- paddle1_pos, out, POS_W, paddle1 top y.
- ball_pos_x, out, POS_W, ball left x.
- ball_pos_y, out, POS_W, ball top y.
- score0, out, 4, points won by player 0.
- score1, out, 4, points won by player 1.
- frame_done, out, 1, one-cycle pulse when outputs update.

Function
REQ-003 On new_dataN, SHALL latch velN = paddleN_speed >> SPEED_SHIFT and dirN; values persist until the next strobe.
REQ-004 SHALL register vert_blank and detect a rising edge; the FSM runs IDLE -> MOVE_PAD -> MOVE_BALL -> COLLIDE -> COMMIT -> IDLE, one cycle per state.
REQ-005 Rising edges arriving outside IDLE SHALL be ignored.
REQ-006 MOVE_PAD SHALL set pad = pad -/+ vel and clamp to [0, SCREEN_H-PADDLE_H] using POS_W+2-bit signed arithmetic, with no wrap.
REQ-007 A strobe in the same cycle as MOVE_PAD SHALL use the previously latched velocity; the new value applies next frame.
REQ-008 P1_MODE=0: paddle1 centre SHALL move toward the ball centre by min(AI_STEP, |difference|), clamped per REQ-006.
REQ-009 MOVE_BALL SHALL add signed vx and vy.
- If y < 0: y=0 and vy negated.
- If y > SCREEN_H-BALL_SIZE: y = SCREEN_H-BALL_SIZE and vy negated.
REQ-010 COLLIDE, paddle0 hit (vx<0, x <= PAD0_X+PADDLE_W, x+BALL_SIZE > PAD0_X, y-overlap): x = PAD0_X+PADDLE_W; vx = +min(|vx|+1, MAX_SPEED).
REQ-011 Paddle1 hit mirrors REQ-010 at PAD1_X = SCREEN_W-PAD0_X-PADDLE_W; on hit, x = PAD1_X-BALL_SIZE and vx is negative.
REQ-012 Miss, defined as x <= 0 or x >= SCREEN_W-BALL_SIZE with no hit:
- The opponent score SHALL increment, saturating at 15.
- The ball SHALL serve from ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2).
- |vx| = |vy| = BALL_SPEED, with vx directed toward the player who missed.
REQ-013 Hit SHALL take priority over miss in the same frame.
REQ-014 COMMIT SHALL copy all internal positions and scores to the output registers simultaneously and pulse frame_done.
- Outputs SHALL change only in COMMIT.
- Latency SHALL be 4 clocks after the edge sampling vert_blank high.

Reset
REQ-015 reset_n low SHALL asynchronously force the following values:
- paddles = (SCREEN_H-PADDLE_H)/2 = 220.
- ball = (316,236), vx = vy = +BALL_SPEED.
- scores = 0, latched velocities = 0, dirs = 0.
- frame_done = 0, FSM = IDLE, edge register = 0.
REQ-016 Reset mid-frame SHALL abort the update with no partial output change.
- After release, a vert_blank that is already high SHALL NOT start a frame until it falls and rises again.

Verification
REQ-017 paddle0_speed=200, dir=0, strobe, then one vert_blank rise -> paddle0_pos 220 -> 226; frame_done pulses 4 clocks later.
REQ-018 paddle0 at 436, speed=255, dir=0 -> paddle0_pos=440 and stays 440 on subsequent frames.
REQ-019 Ball y=471, vy=+2 -> ball_pos_y=472 and vy=-2; the next frame gives 470.
REQ-020 Ball x=2, vx=-2, paddle0 far away -> score1=1, ball=(316,236), vx=-2.
REQ-021 Ball x=25, vx=-2, overlapping paddle0 -> ball_pos_x=24, vx=+3, no score change.
REQ-022 Assert reset_n in MOVE_BALL -> outputs equal reset values immediately, frame_done stays 0.
